// File: rtl/zinde_memory_8bit.sv
// zinde_memory_8bit: 256x8 CPU memory with a byte-stream program loader and
// two memory-mapped I/O ports.
//
// Ports
//   clk, rst             : clock (rising edge) and async active-low reset
//   address, to_memory   : CPU address and write data
//   write                : CPU write enable (ignored while loading)
//   from_memory          : CPU read data, combinational, zero latency
//   ld_start             : pulse that requests a program load
//   ld_valid, ld_data    : loader byte and its valid flag
//   ld_last              : marks the final loader byte
//   ld_ready             : loader may transfer (high in LOAD)
//   ld_done              : one-cycle pulse after the load ends
//   cpu_hold             : high while loading, holds the CPU in reset
//   in_port              : external input, asynchronous to clk
//   out_port             : registered external output
module zinde_memory_8bit #(
  parameter logic [7:0] OUT_ADDR = 8'hFF,
  parameter logic [7:0] IN_ADDR  = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] to_memory,
  input  logic       write,
  output logic [7:0] from_memory,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       cpu_hold,
  input  logic [7:0] in_port,
  output logic [7:0] out_port
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state_q;
  state_t              next_state;
  logic [ADDR_W-1:0]   ld_addr_q;
  logic [DATA_W-1:0]   in_meta_q;
  logic [DATA_W-1:0]   in_sync;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                load_accept;
  logic                load_end;
  logic                load_begin;
  logic                cpu_wr_ram;
  logic                cpu_wr_out;

  // Next-state and write decode; CPU writes are only honoured in IDLE.
  always_comb begin
    next_state  = state_q;
    load_accept = 1'b0;
    load_end    = 1'b0;
    load_begin  = 1'b0;
    cpu_wr_ram  = 1'b0;
    cpu_wr_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write) begin
          if (address == OUT_ADDR) begin
            cpu_wr_out = 1'b1;
          end else if (address != IN_ADDR) begin
            cpu_wr_ram = 1'b1;
          end
        end
        if (ld_start) begin
          load_begin = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        // ld_ready is high for the whole of LOAD, so valid alone accepts.
        if (ld_valid) begin
          load_accept = 1'b1;
          if (ld_last || (ld_addr_q == LAST_ADDR)) begin
            load_end   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, loader counter, registered handshake outputs and I/O registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      ld_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      ld_done   <= 1'b0;
      out_port  <= '0;
      in_meta_q <= '0;
      in_sync   <= '0;
    end else begin
      state_q   <= next_state;
      ld_ready  <= (next_state == LOAD);
      cpu_hold  <= (next_state == LOAD);
      ld_done   <= load_end;
      in_meta_q <= in_port;
      in_sync   <= in_meta_q;
      if (load_begin) begin
        ld_addr_q <= '0;
      end else if (load_accept) begin
        ld_addr_q <= ld_addr_q + ADDR_W'(1);
      end
      if (cpu_wr_out) begin
        out_port <= to_memory;
      end
    end
  end

  // Storage array carries no reset; loader writes ignore the memory map.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[ld_addr_q] <= ld_data;
    end else if (cpu_wr_ram) begin
      mem[address] <= to_memory;
    end
  end

  // Combinational read path with MMIO overlay.
  always_comb begin
    if (address == OUT_ADDR) begin
      from_memory = out_port;
    end else if (address == IN_ADDR) begin
      from_memory = in_sync;
    end else begin
      from_memory = mem[address];
    end
  end

endmodule

// File: doc/zinde_memory_8bit.md
ZINDE_MEMORY_8BIT -- requirements
Module: zinde_memory_8bit

Interface
REQ-001 The block SHALL have parameter OUT_ADDR, default 8'hFF, the memory-mapped output port address.
REQ-002 The block SHALL have parameter IN_ADDR, default 8'hFE, the memory-mapped input port address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 The block SHALL have port address, input, 8, the CPU address.
REQ-006 The block SHALL have port to_memory, input, 8, the CPU write data.
REQ-007 The block SHALL have port write, input, 1, the CPU write enable.
REQ-008 The block SHALL have port from_memory, output, 8, the CPU read data.
REQ-009 The block SHALL have port ld_start, input, 1, a pulse that requests a program load.
REQ-010 The block SHALL have port ld_valid, input, 1, loader byte valid.
REQ-011 The block SHALL have port ld_data, input, 8, loader byte.
REQ-012 The block SHALL have port ld_last, input, 1, marks the final loader byte.
REQ-013 The block SHALL have port ld_ready, output, 1, loader may transfer.
REQ-014 The block SHALL have port ld_done, output, 1, one-cycle pulse at load end.
REQ-015 The block SHALL have port cpu_hold, output, 1, high while loading; the top level holds the CPU in reset with it.
REQ-016 The block SHALL have port in_port, input, 8, external input, asynchronous to clk.
REQ-017 The block SHALL have port out_port, output, 8, the registered external output.

Function
REQ-018 Storage SHALL be 256 x 8, with no reset on the array, so contents are undefined until written.
REQ-019 The FSM SHALL have exactly two states, IDLE and LOAD.
REQ-020 In IDLE: ld_ready=0 and cpu_hold=0.
REQ-021 In LOAD: ld_ready=1 and cpu_hold=1.
REQ-022 IDLE -> LOAD SHALL occur on ld_start=1, which also clears the load counter ld_addr to 0.
REQ-023 A byte is accepted on a rising edge with ld_valid & ld_ready; the accepted byte SHALL be written to mem[ld_addr], then ld_addr increments modulo 256.
REQ-024 LOAD -> IDLE SHALL occur when the accepted byte has ld_last=1 or was written at ld_addr=255; ld_done SHALL be 1 for the following single cycle.
REQ-025 Loader writes SHALL go to the RAM array at every address, including IN_ADDR and OUT_ADDR; the memory map does not apply to the loader.
REQ-026 ld_start during LOAD SHALL be ignored, with no counter restart.
REQ-027 ld_valid in IDLE SHALL be ignored.
REQ-028 CPU write in IDLE: on a rising edge with write=1, address=OUT_ADDR SHALL update out_port and leave the RAM unchanged; address=IN_ADDR SHALL be discarded; any other address SHALL write mem[address].
REQ-029 CPU writes during LOAD SHALL be ignored, including to OUT_ADDR.
REQ-030 ld_start and write in the same IDLE cycle: the CPU write SHALL complete in that cycle, and LOAD SHALL begin the next cycle.
REQ-031 CPU read SHALL be combinational, zero latency, in both states:
- address=OUT_ADDR -> out_port
- address=IN_ADDR -> in_sync
- otherwise -> mem[address]
REQ-032 A read of an address written by the CPU on the previous edge SHALL return the new data.
REQ-033 in_sync SHALL be the output of a two-flop synchronizer on in_port, so a change on in_port is visible at from_memory 2 clk edges later.

Reset
REQ-034 rst=0 SHALL force immediately, without waiting for a clock edge: state=IDLE, ld_addr=0, ld_ready=0, ld_done=0, cpu_hold=0, out_port=8'h00, and both synchronizer stages = 8'h00.
REQ-035 rst=0 in the middle of LOAD SHALL abort the load, keep bytes already written, and produce no ld_done pulse.
REQ-036 Release of rst SHALL be followed by normal operation from the first rising edge with rst=1.

Verification
REQ-037 Program load: ld_start, then bytes 8'h11, 8'h22, 8'h33 with ld_last on 8'h33 -> mem[0..2]=11,22,33; ld_done pulses once; cpu_hold falls in the same cycle; reading address 8'h01 returns 8'h22.
REQ-038 Load wrap: 256 bytes (value = index), ld_last never asserted -> exit after byte 255; mem[8'hFF]=8'hFF in RAM; out_port unchanged at 8'h00.
REQ-039 MMIO: CPU writes 8'hA5 to 8'hFF -> out_port=8'hA5 and a read of 8'hFF returns 8'hA5; then set in_port=8'h3C -> a read of 8'hFE returns 8'h3C after 2 edges and the old value before that.
REQ-040 Write during load: in LOAD, CPU write of 8'h77 to 8'h10 and of 8'h55 to 8'hFF -> mem[8'h10] and out_port unchanged.
REQ-041 Reset mid-load: 2 bytes accepted, then rst=0 -> ld_ready and cpu_hold drop asynchronously; ld_done stays 0; mem[0..1] are retained; out_port=8'h00.
REQ-042 Simultaneous events: ld_start together with a CPU write of 8'h9E to 8'h05 -> mem[8'h05]=8'h9E and ld_ready=1 on the next cycle.
